div_ctrl_unit: RTL and testbench
================================

// Module: div_ctrl_unit
// PURPOSE
//  Control unit for the 8-bit repeated-subtraction divider. Drives the 16x8 register bank's
//  write-port fields (InMuxAdd, RegAdd, WE), read-mux select (OutMuxAdd) and constant (CUconst).
//  Drives the ALU opcode and reads the ALU flags. Computes Q=A/B into R0 and R=A%B into R14.
//  Provides a start/busy/done handshake and a divide-by-zero flag to the top level.
// PARAMETERS
//  DW      8  datapath width (CUconst, loop data)
//  AW      4  register address width
//  R_REM   3  scratch register holding the running remainder
//  R_DIV   4  scratch register holding the divisor
// PORTS
//  clk        in   1   system clock, rising edge
//  rst        in   1   asynchronous, active-low reset (0 = reset)
//  start      in   1   request a division; sampled only in IDLE
//  alu_borrow in   1   ALU flag: 1 when ALUinA < ALUinB under SUB
//  alu_zero   in   1   ALU flag: 1 when ALUout == 0
//  InMuxAdd   out  3   bank input select: 0 InA, 1 InB, 2 CUconst, 3 ALUout, 4 RegOut
//  OutMuxAdd  out  AW  bank read select (RegOut source)
//  RegAdd     out  AW  bank write address
//  WE         out  1   bank write enable
//  CUconst    out  DW  constant to bank
//  ALUop      out  2   00 ADD (R1+R2), 01 SUB (R1-R2); other codes unused
//  busy       out  1   high from the first cycle after start acceptance until done
//  done       out  1   one-cycle pulse when results are final in R0/R14
//  dbz        out  1   divide-by-zero; set with done, held until next accepted start
// BEHAVIOUR
//  - Reset: state=IDLE. All outputs 0, including WE, busy, done and dbz.
//    Reset mid-operation aborts immediately; the bank contents are don't-care.
//  - Outputs are combinational decodes of state. In SUB, WE also depends on alu_borrow.
//  - Start handling: start in IDLE moves the FSM to LDA on the next edge.
//    start in any other state is ignored; there is no queueing.
//  - FSM sequence; each state is one cycle; "Rx<-y" means WE=1, RegAdd=x, InMuxAdd per y:
//    LDA   R_REM<-InA (mux0)                 LDB  R_DIV<-InB (mux1)
//    CLRQ  R0<-CUconst=0 (mux2)              ZLD1 R1<-R_DIV (mux4, OutMuxAdd=R_DIV)
//    ZLD2  R2<-CUconst=0                     ZCHK WE=0, ALUop=SUB
//          ZCHK: alu_zero -> ERR, else -> CLD1
//    CLD1  R1<-R_REM (mux4)                  CLD2 R2<-R_DIV (mux4)
//    SUB   ALUop=SUB
//          SUB: alu_borrow=1 -> WE=0, go WRR
//          SUB: alu_borrow=0 -> R_REM<-ALUout (mux3), go ILD1
//    ILD1  R1<-R0 (mux4)                     ILD2 R2<-CUconst=1
//    INC   ALUop=ADD, R0<-ALUout (mux3) -> CLD1
//    WRR   R14<-R_REM (mux4) -> DONE
//    ERR   R0<-CUconst=8'hFF, R14<-n/a (no write), set dbz -> DONE
//    DONE  done=1, busy=0, WE=0 -> IDLE
//  - Default outputs in non-writing states: WE=0, ALUop=ADD, all other outputs 0.
//  - Latency: start accepted at edge 0. Normal: done high in cycle 11+6*Q. B=0: done high in cycle 8.
//  - Quotient overflow is impossible: Q<=A<=255. R0 increments at most 255 times.
//  - A<B (including A=0): first SUB borrows; Q=0, R=A.
//  - A=0, B=0: reported as dbz; the zero check precedes the loop.
//  - A start pulse coincident with done: ignored; a new start is accepted in IDLE only.
// TESTING
//  1. A=7, B=2, start pulse -> done in cycle 29, R0=3, R14=1, dbz=0, busy high cycles 1..28.
//  2. A=5, B=7 -> done in cycle 11, R0=0, R14=5. Also A=0, B=3 -> R0=0, R14=0, done in cycle 11.
//  3. A=9, B=0 -> done in cycle 8, dbz=1, R0=8'hFF.
//     Then A=8, B=4 -> dbz clears on start; R0=2, R14=0, done in cycle 23.
//  4. A=255, B=1 -> done in cycle 1541, R0=255, R14=0.
//     A=255, B=255 -> R0=1, R14=0, done in cycle 17.
//  5. A=200, B=3; assert start again at cycles 5 and 40 -> both ignored;
//     single done; R0=66, R14=2.
//  6. rst low in cycle 15 of A=100, B=7 -> WE/busy/done/dbz 0 asynchronously; FSM in IDLE.
//     After release, a fresh A=100, B=7 -> R0=14, R14=2.

Source files
------------

// File: rtl/div_ctrl_unit.sv
// Control FSM for the 8-bit repeated-subtraction divider: sequences the 16x8 register bank
// and ALU to leave Q=A/B in R0 and R=A%B in R14, with start/busy/done/dbz handshake.
module div_ctrl_unit #(
    parameter int unsigned DW    = 8,
    parameter int unsigned AW    = 4,
    parameter int unsigned R_REM = 3,
    parameter int unsigned R_DIV = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic          alu_borrow,
    input  logic          alu_zero,
    output logic [2:0]    InMuxAdd,
    output logic [AW-1:0] OutMuxAdd,
    output logic [AW-1:0] RegAdd,
    output logic          WE,
    output logic [DW-1:0] CUconst,
    output logic [1:0]    ALUop,
    output logic          busy,
    output logic          done,
    output logic          dbz
);

    typedef enum logic [3:0] {
        S_IDLE, S_LDA, S_LDB, S_CLRQ, S_ZLD1, S_ZLD2, S_ZCHK, S_CLD1,
        S_CLD2, S_SUB, S_ILD1, S_ILD2, S_INC, S_WRR, S_ERR, S_DONE
    } state_e;

    typedef enum logic [2:0] {
        MUX_INA   = 3'd0,
        MUX_INB   = 3'd1,
        MUX_CONST = 3'd2,
        MUX_ALU   = 3'd3,
        MUX_REG   = 3'd4
    } mux_e;

    typedef enum logic [1:0] {
        OP_ADD = 2'b00,
        OP_SUB = 2'b01
    } op_e;

    state_e r_state;
    logic   r_dbz;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_IDLE;
            r_dbz   <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: if (start) begin
                    r_state <= S_LDA;
                    r_dbz   <= 1'b0;
                end
                S_LDA:  r_state <= S_LDB;
                S_LDB:  r_state <= S_CLRQ;
                S_CLRQ: r_state <= S_ZLD1;
                S_ZLD1: r_state <= S_ZLD2;
                S_ZLD2: r_state <= S_ZCHK;
                S_ZCHK: r_state <= alu_zero ? S_ERR : S_CLD1;
                S_CLD1: r_state <= S_CLD2;
                S_CLD2: r_state <= S_SUB;
                S_SUB:  r_state <= alu_borrow ? S_WRR : S_ILD1;
                S_ILD1: r_state <= S_ILD2;
                S_ILD2: r_state <= S_INC;
                S_INC:  r_state <= S_CLD1;
                S_WRR:  r_state <= S_DONE;
                S_ERR: begin
                    r_state <= S_DONE;
                    r_dbz   <= 1'b1;
                end
                S_DONE: r_state <= S_IDLE;
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign dbz  = r_dbz;
    assign busy = (r_state != S_IDLE) && (r_state != S_DONE);
    assign done = (r_state == S_DONE);

    // Bank/ALU controls decode straight from state; only SUB also looks at the borrow flag.
    always_comb begin
        InMuxAdd  = MUX_INA;
        OutMuxAdd = '0;
        RegAdd    = '0;
        WE        = 1'b0;
        CUconst   = '0;
        ALUop     = OP_ADD;
        case (r_state)
            S_LDA: begin
                WE = 1'b1; RegAdd = AW'(R_REM); InMuxAdd = MUX_INA;
            end
            S_LDB: begin
                WE = 1'b1; RegAdd = AW'(R_DIV); InMuxAdd = MUX_INB;
            end
            S_CLRQ: begin
                WE = 1'b1; RegAdd = AW'(0); InMuxAdd = MUX_CONST;
            end
            S_ZLD1: begin
                WE = 1'b1; RegAdd = AW'(1); InMuxAdd = MUX_REG; OutMuxAdd = AW'(R_DIV);
            end
            S_ZLD2: begin
                WE = 1'b1; RegAdd = AW'(2); InMuxAdd = MUX_CONST;
            end
            S_ZCHK: ALUop = OP_SUB;
            S_CLD1: begin
                WE = 1'b1; RegAdd = AW'(1); InMuxAdd = MUX_REG; OutMuxAdd = AW'(R_REM);
            end
            S_CLD2: begin
                WE = 1'b1; RegAdd = AW'(2); InMuxAdd = MUX_REG; OutMuxAdd = AW'(R_DIV);
            end
            S_SUB: begin
                ALUop = OP_SUB;
                if (!alu_borrow) begin
                    WE = 1'b1; RegAdd = AW'(R_REM); InMuxAdd = MUX_ALU;
                end
            end
            S_ILD1: begin
                WE = 1'b1; RegAdd = AW'(1); InMuxAdd = MUX_REG; OutMuxAdd = AW'(0);
            end
            S_ILD2: begin
                WE = 1'b1; RegAdd = AW'(2); InMuxAdd = MUX_CONST; CUconst = DW'(1);
            end
            S_INC: begin
                WE = 1'b1; RegAdd = AW'(0); InMuxAdd = MUX_ALU; ALUop = OP_ADD;
            end
            S_WRR: begin
                WE = 1'b1; RegAdd = AW'(14); InMuxAdd = MUX_REG; OutMuxAdd = AW'(R_REM);
            end
            S_ERR: begin
                WE = 1'b1; RegAdd = AW'(0); InMuxAdd = MUX_CONST; CUconst = '1;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_div_ctrl_unit.sv
// Bench for div_ctrl_unit: behavioural register bank + ALU around the controller,
// directed divisions checked against hand-computed quotient, remainder and latency.
module tb_div_ctrl_unit;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic       alu_borrow, alu_zero;
    logic [2:0] InMuxAdd;
    logic [3:0] OutMuxAdd, RegAdd;
    logic       WE;
    logic [7:0] CUconst;
    logic [1:0] ALUop;
    logic       busy, done, dbz;

    logic [7:0] in_a, in_b;
    logic [7:0] bank [16];
    logic [7:0] alu_out, din;

    int n_chk  = 0;
    int n_pass = 0;

    always #5 clk = ~clk;

    div_ctrl_unit #(.DW(8), .AW(4), .R_REM(3), .R_DIV(4)) dut (
        .clk(clk), .rst(rst), .start(start),
        .alu_borrow(alu_borrow), .alu_zero(alu_zero),
        .InMuxAdd(InMuxAdd), .OutMuxAdd(OutMuxAdd), .RegAdd(RegAdd), .WE(WE),
        .CUconst(CUconst), .ALUop(ALUop), .busy(busy), .done(done), .dbz(dbz)
    );

    // Datapath environment: ALU works on R1/R2, bank input mux selects the write source.
    always_comb begin
        alu_out    = (ALUop == 2'b01) ? bank[1] - bank[2] : bank[1] + bank[2];
        alu_borrow = (ALUop == 2'b01) && (bank[1] < bank[2]);
        alu_zero   = (alu_out == 8'd0);
        case (InMuxAdd)
            3'd0:    din = in_a;
            3'd1:    din = in_b;
            3'd2:    din = CUconst;
            3'd3:    din = alu_out;
            3'd4:    din = bank[OutMuxAdd];
            default: din = 8'd0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (WE) bank[RegAdd] <= din;
    end

    task automatic chk(input string tag, input int obs, input int exp);
        n_chk++;
        if (obs == exp) n_pass++;
        else $display("FAIL %s: got %0d, want %0d", tag, obs, exp);
    endtask

    // Cycle n is the n-th clock interval after the accepting edge (LDA is cycle 1).
    task automatic run_div(input string nm, input logic [7:0] a, input logic [7:0] b,
                           input int exp_q, input int exp_r, input int exp_cyc,
                           input logic exp_dbz, input int rs1, input int rs2);
        int cyc      = 1;
        int busy_cnt = 0;
        bit got      = 0;
        in_a  = a;
        in_b  = b;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        chk({nm, ".dbz_clr"}, dbz, 0);
        while (cyc <= 3000) begin
            if (done) begin
                got = 1;
                break;
            end
            if (busy) busy_cnt++;
            start = (cyc == rs1 || cyc == rs2) ? 1'b1 : 1'b0;
            @(posedge clk); #1;
            cyc++;
        end
        start = 1'b0;
        if (!got) begin
            chk({nm, ".timeout"}, 0, 1);
            return;
        end
        chk({nm, ".done_cyc"}, cyc, exp_cyc);
        chk({nm, ".busy_cnt"}, busy_cnt, exp_cyc - 1);
        chk({nm, ".busy_at_done"}, busy, 0);
        chk({nm, ".dbz"}, dbz, exp_dbz);
        chk({nm, ".R0"}, bank[0], exp_q);
        if (!exp_dbz) chk({nm, ".R14"}, bank[14], exp_r);
        @(posedge clk); #1;
        chk({nm, ".done_pulse"}, done, 0);
        chk({nm, ".dbz_hold"}, dbz, exp_dbz);
        chk({nm, ".idle_busy"}, busy, 0);
    endtask

    initial begin
        rst   = 1'b0;
        start = 1'b0;
        in_a  = 8'd0;
        in_b  = 8'd0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst.outs", {WE, busy, done, dbz}, 0);
        chk("rst.ctrl", {InMuxAdd, RegAdd, OutMuxAdd, CUconst, ALUop}, 0);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk); #1;
        chk("idle.busy", busy, 0);

        run_div("t1_7_2",    8'd7,   8'd2,   3,   1,  29,   1'b0, 0, 0);
        run_div("t2_5_7",    8'd5,   8'd7,   0,   5,  11,   1'b0, 0, 0);
        run_div("t2_0_3",    8'd0,   8'd3,   0,   0,  11,   1'b0, 0, 0);
        run_div("t3_9_0",    8'd9,   8'd0,   255, 0,  8,    1'b1, 0, 0);
        run_div("t3_8_4",    8'd8,   8'd4,   2,   0,  23,   1'b0, 0, 0);
        run_div("t4_255_1",  8'd255, 8'd1,   255, 0,  1541, 1'b0, 0, 0);
        run_div("t4_255_255",8'd255, 8'd255, 1,   0,  17,   1'b0, 0, 0);
        run_div("t0_0_0",    8'd0,   8'd0,   255, 0,  8,    1'b1, 0, 0);
        run_div("t5_200_3",  8'd200, 8'd3,   66,  2,  407,  1'b0, 5, 40);

        // Abort A=100,B=7 in cycle 15 with an asynchronous reset.
        in_a  = 8'd100;
        in_b  = 8'd7;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (14) begin
            @(posedge clk); #1;
        end
        chk("t6.busy_pre", busy, 1);
        rst = 1'b0;
        #1;
        chk("t6.async_outs", {WE, busy, done, dbz}, 0);
        @(posedge clk); #1;
        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            chk("t6.idle_after", {WE, busy, done}, 0);
        end
        run_div("t6_100_7",  8'd100, 8'd7,   14,  2,  95,   1'b0, 0, 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
